spi_reg_writer: RTL and testbench

SPI_REG_WRITER -- requirements
Module: spi_reg_writer

---
 rtl/spi_reg_pkg.sv | 14 +
 rtl/sync_2ff.sv | 20 ++
 rtl/spi_reg_writer.sv | 101 ++++++++++
 tb/tb_spi_reg_writer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: frame geometry and FSM state encoding shared by the SPI register writer.
package spi_reg_pkg;
    localparam int FRAME_BITS = 24;
    localparam int ADDR_BITS  = 8;
    localparam int DATA_BITS  = 16;
    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        SETUP,
        STROBE,
        RELEASE,
        DRAIN
    } state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit with a selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            q_o    <= RST_VAL;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end
endmodule

// File: rtl/spi_reg_writer.sv
// spi_reg_writer: receives 24-bit SPI frames (addr, data) and issues one-hot register writes with a WCLK strobe.
module spi_reg_writer
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS  = 8,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SCK,
    input  logic                 MOSI,
    input  logic                 CS_N,
    output logic [DATA_BITS-1:0] WDATA,
    output logic [NUM_REGS-1:0]  WE,
    output logic                 WCLK,
    output logic                 FRAME_ERR
);
    logic sck_s, mosi_s, cs_s;
    logic sck_q, armed_q;
    logic [1:0] valid_q;
    state_t state_q;
    logic [FRAME_BITS-1:0] sr_q;
    logic [4:0] cnt_q;
    logic [7:0] cyc_q;
    logic sck_rise, addr_ok;
    logic [ADDR_BITS-1:0] addr;

    sync_2ff #(.RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst(rst), .d_i(SCK),  .q_o(sck_s));
    sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d_i(MOSI), .q_o(mosi_s));
    sync_2ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .d_i(CS_N), .q_o(cs_s));

    assign sck_rise = sck_s & ~sck_q;
    assign addr     = sr_q[FRAME_BITS-1 -: ADDR_BITS];
    assign addr_ok  = 32'(addr) < 32'(NUM_REGS);

    // armed_q needs a genuine CS_N high seen after the synchronizer has flushed its reset value
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sck_q     <= 1'b0;
            armed_q   <= 1'b0;
            valid_q   <= 2'b00;
            sr_q      <= '0;
            cnt_q     <= '0;
            cyc_q     <= '0;
            WDATA     <= '0;
            WE        <= '0;
            WCLK      <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            sck_q     <= sck_s;
            valid_q   <= {valid_q[0], 1'b1};
            FRAME_ERR <= 1'b0;
            if (valid_q[1] && cs_s) armed_q <= 1'b1;
            case (state_q)
                IDLE: if (armed_q && !cs_s) begin
                    state_q <= SHIFT;
                    cnt_q   <= '0;
                    sr_q    <= '0;
                end
                SHIFT: if (cnt_q == 5'(FRAME_BITS)) begin
                    if (addr_ok) begin
                        WE      <= NUM_REGS'(1) << addr;
                        WDATA   <= sr_q[DATA_BITS-1:0];
                        cyc_q   <= '0;
                        state_q <= SETUP;
                    end else begin
                        FRAME_ERR <= 1'b1;
                        state_q   <= DRAIN;
                    end
                end else if (cs_s) begin
                    FRAME_ERR <= 1'b1;
                    state_q   <= IDLE;
                end else if (sck_rise) begin
                    sr_q  <= {sr_q[FRAME_BITS-2:0], mosi_s};
                    cnt_q <= cnt_q + 5'd1;
                end
                SETUP: if (cyc_q == 8'(SETUP_CYC - 1)) begin
                    WCLK    <= 1'b1;
                    cyc_q   <= '0;
                    state_q <= STROBE;
                end else begin
                    cyc_q <= cyc_q + 8'd1;
                end
                STROBE: if (cyc_q == 8'(HOLD_CYC - 1)) begin
                    WCLK    <= 1'b0;
                    state_q <= RELEASE;
                end else begin
                    cyc_q <= cyc_q + 8'd1;
                end
                RELEASE: begin
                    WE      <= '0;
                    state_q <= DRAIN;
                end
                DRAIN: if (cs_s) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_reg_writer.sv
// tb_spi_reg_writer: directed frame table plus reset corner sequences for spi_reg_writer.
module tb_spi_reg_writer;
    logic clk = 1'b0;
    logic rst, SCK, MOSI, CS_N;
    logic [15:0] WDATA;
    logic [7:0] WE;
    logic WCLK, FRAME_ERR;

    spi_reg_writer #(.NUM_REGS(8), .SETUP_CYC(2), .HOLD_CYC(2)) dut (
        .clk(clk), .rst(rst), .SCK(SCK), .MOSI(MOSI), .CS_N(CS_N),
        .WDATA(WDATA), .WE(WE), .WCLK(WCLK), .FRAME_ERR(FRAME_ERR)
    );

    always #5 clk = ~clk;

    int n_run = 0;
    int n_fail = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int fe_cyc = 0, fe_pul = 0, wclk_cyc = 0, wclk_pul = 0, we_rises = 0;
    int we_start = 0, wclk_start = 0;
    logic [7:0] we_last = '0, we_prev = '0;
    logic [15:0] wd_strobe = '0;
    logic fe_prev = 1'b0, wclk_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        fe_prev   <= FRAME_ERR;
        wclk_prev <= WCLK;
        we_prev   <= WE;
        if (FRAME_ERR) fe_cyc <= fe_cyc + 1;
        if (FRAME_ERR && !fe_prev) fe_pul <= fe_pul + 1;
        if (WCLK) wclk_cyc <= wclk_cyc + 1;
        if (WCLK && !wclk_prev) begin
            wclk_pul   <= wclk_pul + 1;
            wclk_start <= cyc;
            wd_strobe  <= WDATA;
        end
        if (WE != 8'h00 && we_prev == 8'h00) begin
            we_rises <= we_rises + 1;
            we_start <= cyc;
            we_last  <= WE;
        end
    end

    typedef struct {
        logic [39:0] frame;
        int          nbits;
        int          gap;
        logic [7:0]  exp_we;
        logic [15:0] exp_wd;
        int          exp_fe;
        int          exp_wclk;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [39:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            MOSI = frame[nbits-1-i];
            SCK  = 1'b0;
            tick(5);
            SCK = 1'b1;
            if (i == 23) rise_cyc = cyc;
            tick(5);
        end
        SCK = 1'b0;
        tick(5);
    endtask

    task automatic send_frame(input logic [39:0] frame, input int nbits, input int gap);
        CS_N = 1'b0;
        tick(5);
        send_bits(frame, nbits);
        CS_N = 1'b1;
        tick(gap);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v[8];
        int s_we, s_fe, s_fc, s_wp, s_wc, s_rst;
        bit found;
        v[0] = '{40'h02A3A3,     24, 20, 8'h04, 16'hA3A3, 0, 2};
        v[1] = '{40'h00000A,     10, 20, 8'h00, 16'hA3A3, 1, 0};
        v[2] = '{40'h09FFFF,     24, 20, 8'h00, 16'hA3A3, 1, 0};
        v[3] = '{40'h0512345678, 40, 20, 8'h20, 16'h1234, 0, 2};
        v[4] = '{40'h000001,     24,  8, 8'h01, 16'h0001, 0, 2};
        v[5] = '{40'h070002,     24, 20, 8'h80, 16'h0002, 0, 2};
        v[6] = '{40'h07BEEF,     24, 20, 8'h80, 16'hBEEF, 0, 2};
        v[7] = '{40'h080000,     24, 20, 8'h00, 16'hBEEF, 1, 0};

        rst = 1'b1; SCK = 1'b0; MOSI = 1'b0; CS_N = 1'b0;
        tick(3);
        chk("rst_we", WE, 8'h00);
        chk("rst_wclk", WCLK, 1'b0);
        chk("rst_fe", FRAME_ERR, 1'b0);
        chk("rst_wdata", WDATA, 16'h0000);
        rst = 1'b0;
        // CS_N held low across reset: frame must be ignored
        send_bits(40'h010055, 24);
        tick(10);
        chk("cslow_we", we_rises, 0);
        chk("cslow_fe", fe_pul, 0);
        chk("cslow_wdata", WDATA, 16'h0000);
        CS_N = 1'b1;
        tick(10);

        for (int i = 0; i < 8; i++) begin
            s_we = we_rises; s_fe = fe_pul; s_fc = fe_cyc; s_wp = wclk_pul; s_wc = wclk_cyc;
            send_frame(v[i].frame, v[i].nbits, v[i].gap);
            chk($sformatf("v%0d_we_rises", i), we_rises - s_we, (v[i].exp_we != 8'h00) ? 1 : 0);
            chk($sformatf("v%0d_fe_pulses", i), fe_pul - s_fe, v[i].exp_fe);
            chk($sformatf("v%0d_fe_cycles", i), fe_cyc - s_fc, v[i].exp_fe);
            chk($sformatf("v%0d_wclk_cycles", i), wclk_cyc - s_wc, v[i].exp_wclk);
            chk($sformatf("v%0d_wclk_pulses", i), wclk_pul - s_wp, (v[i].exp_wclk != 0) ? 1 : 0);
            chk($sformatf("v%0d_wdata", i), WDATA, v[i].exp_wd);
            chk($sformatf("v%0d_we_idle", i), WE, 8'h00);
            chk($sformatf("v%0d_wclk_idle", i), WCLK, 1'b0);
            if (v[i].exp_we != 8'h00) begin
                chk($sformatf("v%0d_we_val", i), we_last, v[i].exp_we);
                chk($sformatf("v%0d_wd_strobe", i), wd_strobe, v[i].exp_wd);
                chk($sformatf("v%0d_setup", i), wclk_start - we_start, 2);
                chk($sformatf("v%0d_latency", i), we_start - rise_cyc, 4);
            end
        end

        // reset asserted while WCLK is high
        found = 1'b0;
        s_rst = 0;
        fork
            send_frame(40'h030055, 24, 0);
            begin
                for (int k = 0; k < 600 && !found; k++) begin
                    @(negedge clk);
                    if (WCLK) found = 1'b1;
                end
                chk("rst_strobe_seen", found, 1'b1);
                if (found) begin
                    rst = 1'b1;
                    @(negedge clk);
                    chk("rst_strobe_wclk", WCLK, 1'b0);
                    chk("rst_strobe_we", WE, 8'h00);
                    chk("rst_strobe_wdata", WDATA, 16'h0000);
                    s_rst = we_rises;
                    rst = 1'b0;
                end
            end
        join
        tick(20);
        chk("rst_no_retry", we_rises - s_rst, 0);
        chk("rst_wdata_hold", WDATA, 16'h0000);
        s_we = we_rises; s_wc = wclk_cyc;
        send_frame(40'h0100AA, 24, 20);
        chk("post_rst_rises", we_rises - s_we, 1);
        chk("post_rst_we", we_last, 8'h02);
        chk("post_rst_wdata", WDATA, 16'h00AA);
        chk("post_rst_wclk", wclk_cyc - s_wc, 2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
